button_conditioner: RTL
=======================

Name: button_conditioner

Overview:
- Upstream front end for the padlock code checker.
- Takes five raw, asynchronous, bouncy push-button levels (four digit keys plus the open key) and synchronises and debounces each one.
- Emits single-cycle press pulses on but_0..but_3 and open, which drive the checker's inputs directly.
- Guarantees at most one pulse per cycle across all five outputs, so the checker never sees two keys in the same cycle.

Parameters:
- DEBOUNCE_CYCLES, 16: consecutive cycles a synchronised input must differ from its debounced state before that state flips. Legal range 2..65535.
- STUCK_CYCLES, 1024: cycles a debounced level may stay high before the channel is declared stuck. Used only with STUCK_DETECT_EN.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- raw_0  input  1  digit key 0, raw level, 1 = pressed
- raw_1  input  1  digit key 1, raw level
- raw_2  input  1  digit key 2, raw level
- raw_3  input  1  digit key 3, raw level
- raw_open  input  1  open key, raw level
- but_0  output  1  one-cycle press pulse, digit 0
- but_1  output  1  one-cycle press pulse, digit 1
- but_2  output  1  one-cycle press pulse, digit 2
- but_3  output  1  one-cycle press pulse, digit 3
- open  output  1  one-cycle press pulse, open key
- stuck  output  5  per-channel stuck flags; bit order {open,3,2,1,0}

Behaviour:
- Reset:
  - One clock; reset is asynchronous and active-low.
  - Reset asserted clears all synchroniser flops, debounced states, counters, pulse registers and stuck flags immediately, without waiting for a clock edge.
  - All outputs read 0 during reset and in the first cycle after release.
- Synchroniser: each raw input passes through a 2-flop synchroniser (sync1, then sync2).
- Debounce, per channel, for a debounced state deb and a counter cnt of width clog2(DEBOUNCE_CYCLES):
  - sync2 == deb: cnt cleared to 0.
  - sync2 != deb and cnt < DEBOUNCE_CYCLES-1: cnt increments.
  - sync2 != deb and cnt == DEBOUNCE_CYCLES-1: deb toggles and cnt is cleared.
  - Any single-cycle glitch back to deb restarts the count.
- Edge detect: a press candidate is raised in the cycle after deb goes 0->1. Releases (1->0) produce no pulse.
- Latency: raw high is first sampled at clock edge 1. The pulse register is set at edge DEBOUNCE_CYCLES+3 and holds for exactly one cycle.
- Arbitration:
  - Fixed priority but_0 > but_1 > but_2 > but_3 > open.
  - Candidates arriving in the same cycle: only the winner pulses. Losers are dropped, not queued.
- Hold: while a key is held, no further pulses occur. A new pulse requires a debounced release followed by a debounced press.
- Output register: all five pulse outputs are registered; no combinational path from any raw input to any output.
- Boundaries:
  - Raw input toggling faster than DEBOUNCE_CYCLES: no pulse ever.
  - Reset mid-debounce: count discarded. A key held through reset release must complete a full debounce before it pulses.
  - cnt never wraps; it saturates at clear.

Optional Feature:
- Macro: STUCK_DETECT_EN.
- Defined:
  - Each channel has a hold counter of width clog2(STUCK_CYCLES+1). It counts while deb is 1 and clears when deb is 0.
  - On reaching STUCK_CYCLES, that channel's stuck bit is set and stays set until reset.
  - A stuck channel produces no further press pulses and does not take part in arbitration. Lower-priority channels then win.
- Not defined: no hold counters are built; stuck is tied to 5'b0.

Test Plan:
- Raw pulse width for DEBOUNCE_CYCLES=4: raw_2 held high from edge 1 -> but_2 high exactly at cycle 7 for one cycle; other outputs 0; stuck = 0.
- Bounce: raw_1 toggles 0/1 every 2 cycles for 40 cycles, then held high for DEBOUNCE_CYCLES=4 -> no pulse during toggling; exactly one but_1 pulse after the stable run.
- Simultaneous press: raw_0, raw_3 and raw_open rise on the same edge -> only but_0 pulses. After releasing all and pressing raw_3 alone -> but_3 pulses once.
- Sequence 2,1,3,0 then open, with full debounced release between keys -> pulses on but_2, but_1, but_3, but_0, open in order, one each, never overlapping.
- Reset: assert reset (0) asynchronously mid-count with raw_1 high -> outputs 0 immediately. After release with raw_1 still high -> single but_1 pulse at DEBOUNCE_CYCLES+3 cycles.
- With STUCK_DETECT_EN, STUCK_CYCLES=20, DEBOUNCE_CYCLES=4: hold raw_0 for 40 cycles -> one but_0 pulse, stuck[0]=1 after 20 high cycles. Release and re-press -> no but_0 pulse. Pressing raw_1 -> but_1 pulses.

Source files
------------

// File: rtl/button_conditioner.sv
// button_conditioner
// Front end for the padlock code checker. Five raw, asynchronous, bouncy
// push-button levels are synchronised, debounced and edge-detected. The
// resulting press candidates are arbitrated so that at most one registered
// single-cycle pulse is emitted per clock.
//
// Ports:
//   clk                  system clock
//   reset                asynchronous, active-low reset
//   raw_0..raw_3         raw digit key levels, 1 = pressed
//   raw_open             raw open key level, 1 = pressed
//   but_0..but_3         one-cycle press pulses, digits 0..3
//   open                 one-cycle press pulse, open key
//   stuck[4:0]           per-channel stuck flags, bit order {open,3,2,1,0}
//
// Optional feature: define STUCK_DETECT_EN to build per-channel hold counters.
// A channel whose debounced level stays high for STUCK_CYCLES cycles is flagged
// stuck until reset and is excluded from arbitration. Without the macro, stuck
// reads constant zero.

module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int STUCK_CYCLES    = 1024
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       raw_0,
    input  logic       raw_1,
    input  logic       raw_2,
    input  logic       raw_3,
    input  logic       raw_open,
    output logic       but_0,
    output logic       but_1,
    output logic       but_2,
    output logic       but_3,
    output logic       open,
    output logic [4:0] stuck
);

    localparam int               CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [4:0]       raw_vec;
    logic [4:0]       sync1_p0;
    logic [4:0]       sync2_p1;
    logic [4:0]       deb_p2;
    logic [CNT_W-1:0] cnt_p2 [5];
    logic [4:0]       deb_d_p3;
    logic [4:0]       cand;
    logic [4:0]       grant;
    logic [4:0]       stuck_mask;
    logic [4:0]       pulse_p4;

    // Bit index equals priority rank: bit 0 (digit 0) is the highest.
    assign raw_vec = {raw_open, raw_3, raw_2, raw_1, raw_0};

    // Stage p0/p1: two-flop synchroniser
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_p0 <= '0;
            sync2_p1 <= '0;
        end else begin
            sync1_p0 <= raw_vec;
            sync2_p1 <= sync1_p0;
        end
    end

    // Stage p2: debounce. The debounced state flips only after the
    // synchronised level has disagreed with it for DEBOUNCE_CYCLES
    // consecutive cycles; any agreeing cycle restarts the count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            deb_p2 <= '0;
            for (int i = 0; i < 5; i++) begin
                cnt_p2[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 5; i++) begin
                if (sync2_p1[i] == deb_p2[i]) begin
                    cnt_p2[i] <= '0;
                end else if (cnt_p2[i] == CNT_MAX) begin
                    deb_p2[i] <= ~deb_p2[i];
                    cnt_p2[i] <= '0;
                end else begin
                    cnt_p2[i] <= cnt_p2[i] + 1'b1;
                end
            end
        end
    end

    // Stage p3: previous debounced state for rising-edge detection
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            deb_d_p3 <= '0;
        end else begin
            deb_d_p3 <= deb_p2;
        end
    end

`ifdef STUCK_DETECT_EN
    localparam int                HOLD_W   = $clog2(STUCK_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(STUCK_CYCLES);

    logic [HOLD_W-1:0] hold_cnt [5];
    logic [4:0]        stuck_q;

    // Hold counters saturate at the threshold; the stuck flag is sticky
    // until reset even after the key is released.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stuck_q <= '0;
            for (int i = 0; i < 5; i++) begin
                hold_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 5; i++) begin
                if (!deb_p2[i]) begin
                    hold_cnt[i] <= '0;
                end else if (hold_cnt[i] != HOLD_MAX) begin
                    hold_cnt[i] <= hold_cnt[i] + 1'b1;
                end
                if (hold_cnt[i] == HOLD_MAX) begin
                    stuck_q[i] <= 1'b1;
                end
            end
        end
    end

    assign stuck_mask = stuck_q;
    assign stuck      = stuck_q;
`else
    // No hold counters: stuck reads constant zero. The threshold is folded
    // in with a zero mask so the parameter set is identical in both builds.
    assign stuck_mask = 5'b0;
    assign stuck      = 5'(STUCK_CYCLES) & 5'b0;
`endif

    // Press candidate: debounced 0->1 seen one cycle late; stuck channels
    // never compete.
    assign cand = deb_p2 & ~deb_d_p3 & ~stuck_mask;

    // Isolate the lowest set bit (two's-complement trick), which is the
    // highest-priority candidate. Losing candidates are simply dropped.
    assign grant = cand & (~cand + 5'd1);

    // Stage p4: registered pulse outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pulse_p4 <= '0;
        end else begin
            pulse_p4 <= grant;
        end
    end

    assign but_0 = pulse_p4[0];
    assign but_1 = pulse_p4[1];
    assign but_2 = pulse_p4[2];
    assign but_3 = pulse_p4[3];
    assign open  = pulse_p4[4];

endmodule
